// File: rtl/obi_mc_read_dma_if.sv
// OBI manager port bundle for obi_mc_read_dma.
// Request side (req/addr/we/be/wdata/aid) is driven by the master modport;
// grant and response (gnt/rvalid/rdata/rid/err) come back from the slave side.
interface obi_mc_read_dma_if #(
  parameter int unsigned IdWidth = 4
);
  logic               req;
  logic [31:0]        addr;
  logic               we;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic [IdWidth-1:0] aid;
  logic               gnt;
  logic               rvalid;
  logic [31:0]        rdata;
  logic [IdWidth-1:0] rid;
  logic               err;

  modport master (
    output req, addr, we, be, wdata, aid,
    input  gnt, rvalid, rdata, rid, err
  );

  modport slave (
    input  req, addr, we, be, wdata, aid,
    output gnt, rvalid, rdata, rid, err
  );
endinterface

// File: rtl/obi_mc_read_dma.sv
// Multi-channel OBI read DMA: NumCh command/stream channels share one OBI
// manager port with round-robin arbitration, per-channel read credits,
// rid-routed response FIFOs, byte-enable framing and sticky error flags.
// Optional stall counters are built when OBI_MC_DMA_PERF_CNT_EN is defined.
module obi_mc_read_dma #(
  parameter int unsigned NumCh          = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned LenWidth       = 16,
  parameter int unsigned UserWidth      = 6,
  parameter int unsigned IdWidth        = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             testmode_i,
  input  logic [NumCh-1:0]                 cmd_valid_i,
  output logic [NumCh-1:0]                 cmd_ready_o,
  input  logic [NumCh-1:0][31:0]           cmd_addr_i,
  input  logic [NumCh-1:0][LenWidth-1:0]   cmd_len_i,
  input  logic [NumCh-1:0][UserWidth-1:0]  cmd_user_i,
  obi_mc_read_dma_if.master                mgr,
  output logic [NumCh-1:0]                 str_valid_o,
  input  logic [NumCh-1:0]                 str_ready_i,
  output logic [NumCh-1:0][31:0]           str_data_o,
  output logic [NumCh-1:0][3:0]            str_be_o,
  output logic [NumCh-1:0]                 str_last_o,
  output logic [NumCh-1:0][UserWidth-1:0]  str_user_o,
  output logic [NumCh-1:0]                 busy_o,
  output logic [NumCh-1:0]                 err_o,
  output logic [NumCh-1:0][31:0]           perf_stall_o
);

  localparam int unsigned ChW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned WW   = LenWidth + 1;

  typedef enum logic {IDLE, ACTIVE} ch_state_e;

  ch_state_e          state_q      [NumCh];
  ch_state_e          state_d      [NumCh];
  logic [31:0]        addr_q       [NumCh];
  logic [31:0]        addr_d       [NumCh];
  logic [WW-1:0]      req_left_q   [NumCh];
  logic [WW-1:0]      req_left_d   [NumCh];
  logic [WW-1:0]      beats_left_q [NumCh];
  logic [WW-1:0]      beats_left_d [NumCh];
  logic [NumCh-1:0]   first_q, first_d;
  logic [3:0]         first_be_q   [NumCh];
  logic [3:0]         first_be_d   [NumCh];
  logic [3:0]         last_be_q    [NumCh];
  logic [3:0]         last_be_d    [NumCh];
  logic [UserWidth-1:0] user_q     [NumCh];
  logic [UserWidth-1:0] user_d     [NumCh];
  logic [NumCh-1:0]   err_q, err_d;
  logic [3:0]         infl_q       [NumCh];
  logic [3:0]         infl_d       [NumCh];
  logic [3:0]         cnt_q        [NumCh];
  logic [3:0]         cnt_d        [NumCh];
  logic [PtrW-1:0]    wptr_q       [NumCh];
  logic [PtrW-1:0]    wptr_d       [NumCh];
  logic [PtrW-1:0]    rptr_q       [NumCh];
  logic [PtrW-1:0]    rptr_d       [NumCh];
  logic [31:0]        mem_q        [NumCh][MaxOutstanding];
  logic [ChW-1:0]     rr_q, rr_d, hold_ch_q, hold_ch_d;
  logic               hold_q, hold_d;

  logic [NumCh-1:0]   elig, acc, push, pop, gnt_ch;
  logic               arb_req;
  logic [ChW-1:0]     arb_ch;
  logic               rsp_ok;
  logic [ChW-1:0]     rid_ch;
  logic               unused_ok;

  assign unused_ok = testmode_i;

  // Issue eligibility: active, words left to request, credit available.
  always_comb begin
    for (int unsigned c = 0; c < NumCh; c++) begin
      elig[c] = (state_q[c] == ACTIVE) && (req_left_q[c] != '0) &&
                ((5'(infl_q[c]) + 5'(cnt_q[c])) < 5'(MaxOutstanding));
    end
  end

  // Round-robin pick; a pending ungranted request keeps its winner.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    arb_req = 1'b0;
    arb_ch  = '0;
    if (hold_q) begin
      arb_req = 1'b1;
      arb_ch  = hold_ch_q;
    end else begin
      for (int unsigned i = 0; i < NumCh; i++) begin
        idx = (32'(rr_q) + i) % NumCh;
        if (!arb_req && elig[idx]) begin
          arb_req = 1'b1;
          arb_ch  = ChW'(idx);
        end
      end
    end
  end

  assign mgr.req   = arb_req;
  assign mgr.addr  = addr_q[arb_ch];
  assign mgr.we    = 1'b0;
  assign mgr.be    = 4'hF;
  assign mgr.wdata = '0;
  assign mgr.aid   = IdWidth'(arb_ch);

  // Responses for out-of-range ids or idle channels are dropped.
  always_comb begin
    rid_ch = ChW'(mgr.rid);
    rsp_ok = mgr.rvalid && (32'(mgr.rid) < NumCh) && (state_q[rid_ch] == ACTIVE);
  end

  // Stream outputs straight from registered FIFO/state.
  always_comb begin
    for (int unsigned c = 0; c < NumCh; c++) begin
      cmd_ready_o[c] = (state_q[c] == IDLE);
      busy_o[c]      = (state_q[c] == ACTIVE);
      err_o[c]       = err_q[c];
      str_valid_o[c] = (cnt_q[c] != '0);
      str_data_o[c]  = mem_q[c][rptr_q[c]];
      str_last_o[c]  = (beats_left_q[c] == WW'(1));
      str_be_o[c]    = (first_q[c] ? first_be_q[c] : 4'hF) &
                       (str_last_o[c] ? last_be_q[c] : 4'hF);
      str_user_o[c]  = user_q[c];
    end
  end

  // Per-channel next state: accept, grant, response push, stream pop.
  always_comb begin
    hold_d    = arb_req && !mgr.gnt;
    hold_ch_d = arb_ch;
    rr_d      = rr_q;
    if (arb_req && mgr.gnt) begin
      rr_d = (arb_ch == ChW'(NumCh - 1)) ? '0 : arb_ch + 1'b1;
    end
    for (int unsigned c = 0; c < NumCh; c++) begin
      state_d[c]      = state_q[c];
      addr_d[c]       = addr_q[c];
      req_left_d[c]   = req_left_q[c];
      beats_left_d[c] = beats_left_q[c];
      first_d[c]      = first_q[c];
      first_be_d[c]   = first_be_q[c];
      last_be_d[c]    = last_be_q[c];
      user_d[c]       = user_q[c];
      err_d[c]        = err_q[c];
      wptr_d[c]       = wptr_q[c];
      rptr_d[c]       = rptr_q[c];

      acc[c]    = cmd_valid_i[c] && (state_q[c] == IDLE);
      push[c]   = rsp_ok && (rid_ch == ChW'(c));
      pop[c]    = str_valid_o[c] && str_ready_i[c];
      gnt_ch[c] = arb_req && mgr.gnt && (arb_ch == ChW'(c));

      infl_d[c] = infl_q[c] + {3'b0, gnt_ch[c]} - {3'b0, push[c]};
      cnt_d[c]  = cnt_q[c] + {3'b0, push[c]} - {3'b0, pop[c]};

      if (gnt_ch[c]) begin
        addr_d[c]     = addr_q[c] + 32'd4;
        req_left_d[c] = req_left_q[c] - 1'b1;
      end
      if (push[c]) begin
        wptr_d[c] = (wptr_q[c] == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q[c] + 1'b1;
        if (mgr.err) err_d[c] = 1'b1;
      end
      if (pop[c]) begin
        rptr_d[c]       = (rptr_q[c] == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q[c] + 1'b1;
        beats_left_d[c] = beats_left_q[c] - 1'b1;
        first_d[c]      = 1'b0;
        if (beats_left_q[c] == WW'(1)) state_d[c] = IDLE;
      end
      if (acc[c]) begin
        err_d[c] = 1'b0;
        if (cmd_len_i[c] != '0) begin
          state_d[c]      = ACTIVE;
          addr_d[c]       = {cmd_addr_i[c][31:2], 2'b00};
          req_left_d[c]   = (WW'(cmd_addr_i[c][1:0]) + WW'(cmd_len_i[c]) + WW'(3)) >> 2;
          beats_left_d[c] = (WW'(cmd_addr_i[c][1:0]) + WW'(cmd_len_i[c]) + WW'(3)) >> 2;
          first_d[c]      = 1'b1;
          first_be_d[c]   = 4'hF << cmd_addr_i[c][1:0];
          last_be_d[c]    = 4'hF >> (2'd3 - (cmd_addr_i[c][1:0] + cmd_len_i[c][1:0] - 2'd1));
          user_d[c]       = cmd_user_i[c];
        end
      end
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      hold_q    <= 1'b0;
      hold_ch_q <= '0;
      first_q   <= '0;
      err_q     <= '0;
      for (int unsigned c = 0; c < NumCh; c++) begin
        state_q[c]      <= IDLE;
        addr_q[c]       <= '0;
        req_left_q[c]   <= '0;
        beats_left_q[c] <= '0;
        first_be_q[c]   <= '0;
        last_be_q[c]    <= '0;
        user_q[c]       <= '0;
        infl_q[c]       <= '0;
        cnt_q[c]        <= '0;
        wptr_q[c]       <= '0;
        rptr_q[c]       <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      hold_ch_q <= hold_ch_d;
      first_q   <= first_d;
      err_q     <= err_d;
      for (int unsigned c = 0; c < NumCh; c++) begin
        state_q[c]      <= state_d[c];
        addr_q[c]       <= addr_d[c];
        req_left_q[c]   <= req_left_d[c];
        beats_left_q[c] <= beats_left_d[c];
        first_be_q[c]   <= first_be_d[c];
        last_be_q[c]    <= last_be_d[c];
        user_q[c]       <= user_d[c];
        infl_q[c]       <= infl_d[c];
        cnt_q[c]        <= cnt_d[c];
        wptr_q[c]       <= wptr_d[c];
        rptr_q[c]       <= rptr_d[c];
      end
    end
  end

  // Response data storage; contents are don't-care while a FIFO is empty.
  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= mgr.rdata;
    end
  end

`ifdef OBI_MC_DMA_PERF_CNT_EN
  logic [31:0] stall_q [NumCh];

  // Saturating count of stalled stream cycles, restarted per command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NumCh; c++) stall_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NumCh; c++) begin
        if (acc[c]) begin
          stall_q[c] <= '0;
        end else if (str_valid_o[c] && !str_ready_i[c] && (stall_q[c] != '1)) begin
          stall_q[c] <= stall_q[c] + 32'd1;
        end
      end
    end
  end

  // Expose counters.
  always_comb begin
    for (int unsigned c = 0; c < NumCh; c++) perf_stall_o[c] = stall_q[c];
  end
`else
  assign perf_stall_o = '0;
`endif

endmodule
